// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: default widths, the
// hard-wired zero register, ALU select encodings and the per-edge update action.
package id_ex_operand_stage_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;

  // Register index that always reads as zero and is never forwarded.
  localparam int REG_ZERO = 0;

  // ALU A operand source.
  typedef enum logic [1:0] {
    ALUA_RS    = 2'b00,
    ALUA_PC    = 2'b01,
    ALUA_SHAMT = 2'b10,
    ALUA_ZERO  = 2'b11
  } alua_sel_e;

  // ALU B operand source.
  typedef enum logic [1:0] {
    ALUB_RT   = 2'b00,
    ALUB_IMM  = 2'b01,
    ALUB_FOUR = 2'b10,
    ALUB_ZERO = 2'b11
  } alub_sel_e;

  // What the ID/EX register does on the next clock edge.
  typedef enum logic [1:0] {
    UPD_CAPTURE = 2'b00,
    UPD_HOLD    = 2'b01,
    UPD_BUBBLE  = 2'b10
  } upd_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forwarding mux: returns the youngest in-flight value of a source
// register (EX, then MEM, then WB), falling back to register-file data.
// Register zero always reads as zero and is never forwarded.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic [AW-1:0] i_raddr,
  input  logic [DW-1:0] i_rf_data,
  input  logic          i_ex_we,
  input  logic [AW-1:0] i_ex_waddr,
  input  logic [DW-1:0] i_ex_data,
  input  logic          i_mem_we,
  input  logic [AW-1:0] i_mem_waddr,
  input  logic [DW-1:0] i_mem_data,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_waddr,
  input  logic [DW-1:0] i_wb_data,
  output logic [DW-1:0] o_data
);

  logic w_is_zero;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_is_zero = (i_raddr == AW'(REG_ZERO));
  assign w_ex_hit  = i_ex_we  && (i_ex_waddr  == i_raddr);
  assign w_mem_hit = i_mem_we && (i_mem_waddr == i_raddr);
  assign w_wb_hit  = i_wb_we  && (i_wb_waddr  == i_raddr);

  // Select the operand value, youngest producer first.
  always_comb begin
    // NOTE: default assigned first so every path drives o_data; a missing branch would infer a latch.
    o_data = i_rf_data;
    if (w_is_zero) begin
      o_data = '0;
    end else if (w_ex_hit) begin
      o_data = i_ex_data;
    end else if (w_mem_hit) begin
      o_data = i_mem_data;
    end else if (w_wb_hit) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and operand producer. Forwards EX/MEM/WB results
// into the rs/rt operands, detects load-use hazards (one bubble), and applies
// flush > stall > load-use > normal when deciding what EX captures.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_extern,
  input  logic [1:0]    id_alua_sel,
  input  logic [1:0]    id_alub_sel,
  input  logic [AW-1:0] id_waddr,
  input  logic          id_we,
  input  logic          id_memread,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  output logic [DW-1:0] rdata1_ex,
  output logic [DW-1:0] rdata2_ex,
  output logic [DW-1:0] extern_ex,
  output logic [1:0]    alua_sel_ex,
  output logic [1:0]    alub_sel_ex,
  output logic [AW-1:0] waddr_ex,
  output logic          we_ex,
  output logic          memread_ex,
  output logic          valid_ex,
  output logic          load_use_stall
);

  // Everything the EX stage receives from ID; an all-zero value is a bubble.
  typedef struct packed {
    logic          valid;
    logic          we;
    logic          memread;
    logic [AW-1:0] waddr;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] ext;
    alua_sel_e     alua_sel;
    alub_sel_e     alub_sel;
  } ex_reg_t;

  ex_reg_t       r_ex;
  ex_reg_t       w_ex_next;
  ex_reg_t       w_capture;
  upd_e          w_upd;

  logic          w_ex_fwd_we;
  logic          w_ex_is_load;
  logic          w_rs_dep;
  logic          w_rt_dep;
  logic          w_load_use_raw;
  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_op2;

  // An instruction in EX can forward its ALU result only if it is a real,
  // register-writing non-load; a load's data is not available until MEM.
  assign w_ex_fwd_we  = r_ex.valid && r_ex.we && !r_ex.memread;

  // Load in EX that targets a real register is a potential hazard source.
  assign w_ex_is_load = r_ex.valid && r_ex.memread && r_ex.we &&
                        (r_ex.waddr != AW'(REG_ZERO));

  // Only operands the ID instruction actually reads can create a dependency.
  assign w_rs_dep = id_use_rs && (id_rs == r_ex.waddr);
  assign w_rt_dep = id_use_rt && (id_rt == r_ex.waddr);

  assign w_load_use_raw = w_ex_is_load && id_valid && (w_rs_dep || w_rt_dep);

  // A global stall freezes everything anyway, so no separate load-use hold.
  assign load_use_stall = w_load_use_raw && !stall;

  id_ex_operand_stage_fwd_mux #(
    .DW (DW),
    .AW (AW)
  ) u_fwd_rs (
    .i_raddr     (id_rs),
    .i_rf_data   (id_rdata1),
    .i_ex_we     (w_ex_fwd_we),
    .i_ex_waddr  (r_ex.waddr),
    .i_ex_data   (ex_result),
    .i_mem_we    (mem_we),
    .i_mem_waddr (mem_waddr),
    .i_mem_data  (mem_wdata),
    .i_wb_we     (wb_we),
    .i_wb_waddr  (wb_waddr),
    .i_wb_data   (wb_wdata),
    .o_data      (w_op1)
  );

  id_ex_operand_stage_fwd_mux #(
    .DW (DW),
    .AW (AW)
  ) u_fwd_rt (
    .i_raddr     (id_rt),
    .i_rf_data   (id_rdata2),
    .i_ex_we     (w_ex_fwd_we),
    .i_ex_waddr  (r_ex.waddr),
    .i_ex_data   (ex_result),
    .i_mem_we    (mem_we),
    .i_mem_waddr (mem_waddr),
    .i_mem_data  (mem_wdata),
    .i_wb_we     (wb_we),
    .i_wb_waddr  (wb_waddr),
    .i_wb_data   (wb_wdata),
    .o_data      (w_op2)
  );

  // Assemble the ID instruction as it would appear in EX.
  always_comb begin
    w_capture          = '0;
    w_capture.valid    = 1'b1;
    w_capture.we       = id_we;
    w_capture.memread  = id_memread;
    w_capture.waddr    = id_waddr;
    w_capture.rdata1   = w_op1;
    w_capture.rdata2   = w_op2;
    w_capture.ext      = id_extern;
    w_capture.alua_sel = alua_sel_e'(id_alua_sel);
    w_capture.alub_sel = alub_sel_e'(id_alub_sel);
  end

  // Decide the update action: flush > stall > load-use / empty ID > capture.
  always_comb begin
    w_upd = UPD_CAPTURE;
    if (flush) begin
      w_upd = UPD_BUBBLE;
    end else if (stall) begin
      w_upd = UPD_HOLD;
    end else if (w_load_use_raw || !id_valid) begin
      w_upd = UPD_BUBBLE;
    end
  end

  // Next EX contents for the chosen action.
  always_comb begin
    w_ex_next = r_ex;
    case (w_upd)
      UPD_CAPTURE: w_ex_next = w_capture;
      UPD_BUBBLE:  w_ex_next = '0;
      default:     w_ex_next = r_ex;
    endcase
  end

  // ID/EX register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex <= '0;
    end else begin
      // NOTE: non-blocking so all EX fields update together from pre-edge values.
      r_ex <= w_ex_next;
    end
  end

  assign valid_ex    = r_ex.valid;
  assign we_ex       = r_ex.we;
  assign memread_ex  = r_ex.memread;
  assign waddr_ex    = r_ex.waddr;
  assign rdata1_ex   = r_ex.rdata1;
  assign rdata2_ex   = r_ex.rdata2;
  assign extern_ex   = r_ex.ext;
  assign alua_sel_ex = r_ex.alua_sel;
  assign alub_sel_ex = r_ex.alub_sel;

endmodule
